// File: rtl/vxe_axi_regio_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to VxEngine RegIO bridge.
package vxe_axi_regio_bridge_pkg;

    localparam int unsigned IDX_W     = 10;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = 4;
    localparam int unsigned RESP_W    = 2;
    localparam int unsigned TMO_CNT_W = 16;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [DATA_W-1:0] TMO_RDATA   = 32'hdead_beef;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} r_state_t;

    // Write-path registers: state, captured AW/W payload and all registered outputs
    typedef struct packed {
        w_state_t            state;
        logic                aw_cap;
        logic                w_cap;
        logic [IDX_W-1:0]    idx;
        logic [DATA_W-1:0]   data;
        logic [STRB_W-1:0]   strb;
        logic [RESP_W-1:0]   bresp;
        logic                bvalid;
        logic                awready;
        logic                wready;
        logic                wenable;
    } w_ctx_t;

    typedef struct packed {
        r_state_t            state;
        logic [IDX_W-1:0]    idx;
        logic [DATA_W-1:0]   rdata;
        logic [RESP_W-1:0]   rresp;
        logic                rvalid;
        logic                arready;
        logic                renable;
    } r_ctx_t;

    function automatic logic [RESP_W-1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/vxe_axi_regio_bridge_if.sv
// AXI4-Lite slave channels plus RegIO initiator signals of the bridge.
interface vxe_axi_regio_bridge_if #(parameter int unsigned ADDR_W = 12);
    import vxe_axi_regio_bridge_pkg::*;

    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [RESP_W-1:0] s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [DATA_W-1:0] s_rdata;
    logic [RESP_W-1:0] s_rresp;
    logic              s_rvalid;
    logic              s_rready;

    logic [IDX_W-1:0]  o_wreg_idx;
    logic [DATA_W-1:0] o_wdata;
    logic              o_wenable;
    logic              i_waccept;
    logic              i_werror;
    logic [IDX_W-1:0]  o_rreg_idx;
    logic              o_renable;
    logic [DATA_W-1:0] i_rdata;
    logic              i_raccept;
    logic              i_rerror;

    // Bridge side
    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
               i_waccept, i_werror, i_rdata, i_raccept, i_rerror,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid,
               o_wreg_idx, o_wdata, o_wenable, o_rreg_idx, o_renable
    );

    // Host and responder side
    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
               i_waccept, i_werror, i_rdata, i_raccept, i_rerror,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid,
               o_wreg_idx, o_wdata, o_wenable, o_rreg_idx, o_renable
    );

endinterface

// File: rtl/vxe_regio_tmo.sv
// Accept-timeout counter for one RegIO request path; TMO_CYCLES = 0 disables it.
module vxe_regio_tmo
    import vxe_axi_regio_bridge_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic accept,
    output logic expire_c
);

    logic [TMO_CNT_W-1:0] cnt;

    // Held at zero outside REQ so every request starts counting from 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run && !accept) begin
            cnt <= cnt + TMO_CNT_W'(1);
        end
    end

    // An accept in the expiring cycle wins as a normal completion
    assign expire_c = (TMO_CYCLES != 0) && run && !accept &&
                      (cnt == TMO_CNT_W'(TMO_CYCLES - 1));

endmodule

// File: rtl/vxe_axi_regio_bridge.sv
// AXI4-Lite slave issuing VxEngine RegIO register reads/writes; independent read and write paths.
module vxe_axi_regio_bridge
    import vxe_axi_regio_bridge_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    vxe_axi_regio_bridge_if.slave bus
);

    w_ctx_t w_q, w_d;
    r_ctx_t r_q, r_d;
    logic   aw_hs, w_hs, ar_hs;
    logic   w_expire_c, r_expire_c;
    logic   unused_addr;

    // Only addr[11:2] selects a register
    assign unused_addr = ^{bus.s_awaddr, bus.s_araddr};

    vxe_regio_tmo #(.TMO_CYCLES(TMO_CYCLES)) u_wtmo (
        .clk      (clk),
        .rst      (rst),
        .start    (w_q.state != W_REQ),
        .run      (w_q.state == W_REQ),
        .accept   (bus.i_waccept),
        .expire_c (w_expire_c)
    );

    vxe_regio_tmo #(.TMO_CYCLES(TMO_CYCLES)) u_rtmo (
        .clk      (clk),
        .rst      (rst),
        .start    (r_q.state != R_REQ),
        .run      (r_q.state == R_REQ),
        .accept   (bus.i_raccept),
        .expire_c (r_expire_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_q <= '0;
        else     w_q <= w_d;
    end

    // Write path: AW and W captured independently, then one RegIO write
    always_comb begin
        w_d   = w_q;
        aw_hs = bus.s_awvalid && w_q.awready;
        w_hs  = bus.s_wvalid && w_q.wready;
        case (w_q.state)
            W_IDLE: begin
                if (aw_hs) begin
                    w_d.aw_cap = 1'b1;
                    w_d.idx    = bus.s_awaddr[11:2];
                end
                if (w_hs) begin
                    w_d.w_cap = 1'b1;
                    w_d.data  = bus.s_wdata;
                    w_d.strb  = bus.s_wstrb;
                end
                if (w_d.aw_cap && w_d.w_cap) begin
                    // Registers are word-only; partial strobes are refused without a RegIO write
                    if (w_d.strb != '1) begin
                        w_d.state  = W_RESP;
                        w_d.bresp  = RESP_SLVERR;
                        w_d.bvalid = 1'b1;
                    end else begin
                        w_d.state   = W_REQ;
                        w_d.wenable = 1'b1;
                    end
                end
            end
            W_REQ: begin
                if (bus.i_waccept || w_expire_c) begin
                    w_d.state   = W_RESP;
                    w_d.wenable = 1'b0;
                    w_d.bvalid  = 1'b1;
                    w_d.bresp   = bus.i_waccept ? resp_of(bus.i_werror) : RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (bus.s_bready) begin
                    w_d.state  = W_IDLE;
                    w_d.bvalid = 1'b0;
                    w_d.aw_cap = 1'b0;
                    w_d.w_cap  = 1'b0;
                end
            end
            default: w_d.state = W_IDLE;
        endcase
        w_d.awready = (w_d.state == W_IDLE) && !w_d.aw_cap;
        w_d.wready  = (w_d.state == W_IDLE) && !w_d.w_cap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= r_d;
    end

    // Read path: one RegIO read per AR, data and status latched at accept
    always_comb begin
        r_d   = r_q;
        ar_hs = bus.s_arvalid && r_q.arready;
        case (r_q.state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_d.state   = R_REQ;
                    r_d.idx     = bus.s_araddr[11:2];
                    r_d.renable = 1'b1;
                end
            end
            R_REQ: begin
                if (bus.i_raccept || r_expire_c) begin
                    r_d.state   = R_RESP;
                    r_d.renable = 1'b0;
                    r_d.rvalid  = 1'b1;
                    r_d.rdata   = bus.i_raccept ? bus.i_rdata : TMO_RDATA;
                    r_d.rresp   = bus.i_raccept ? resp_of(bus.i_rerror) : RESP_SLVERR;
                end
            end
            R_RESP: begin
                if (bus.s_rready) begin
                    r_d.state  = R_IDLE;
                    r_d.rvalid = 1'b0;
                end
            end
            default: r_d.state = R_IDLE;
        endcase
        r_d.arready = (r_d.state == R_IDLE);
    end

    assign bus.s_awready  = w_q.awready;
    assign bus.s_wready   = w_q.wready;
    assign bus.s_bvalid   = w_q.bvalid;
    assign bus.s_bresp    = w_q.bresp;
    assign bus.o_wenable  = w_q.wenable;
    assign bus.o_wreg_idx = w_q.idx;
    assign bus.o_wdata    = w_q.data;

    assign bus.s_arready  = r_q.arready;
    assign bus.s_rvalid   = r_q.rvalid;
    assign bus.s_rdata    = r_q.rdata;
    assign bus.s_rresp    = r_q.rresp;
    assign bus.o_renable  = r_q.renable;
    assign bus.o_rreg_idx = r_q.idx;

endmodule

// File: tb/tb_vxe_axi_regio_bridge.sv
// Directed bench for vxe_axi_regio_bridge with scoreboard queues for B, R and RegIO writes.
module tb_vxe_axi_regio_bridge;
    import vxe_axi_regio_bridge_pkg::*;

    localparam int unsigned TMO = 8;

    typedef struct packed {
        logic [9:0]  idx;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vxe_axi_regio_bridge_if #(.ADDR_W(12)) bus();

    vxe_axi_regio_bridge #(.TMO_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Responder model: accepts on the first enable cycle when allowed
    logic        wacc_en, racc_en, werr, rerr;
    logic [31:0] rd_val;
    assign bus.i_waccept = wacc_en & bus.o_wenable;
    assign bus.i_werror  = werr;
    assign bus.i_raccept = racc_en & bus.o_renable;
    assign bus.i_rerror  = rerr;
    assign bus.i_rdata   = rd_val;

    int n_checks = 0;
    int n_fail   = 0;
    int wen_cycles = 0;
    int ren_cycles = 0;
    int rv_cycles  = 0;

    wr_t        wr_obs[$];
    wr_t        exp_w[$];
    logic [1:0] exp_b[$];
    rd_t        exp_r[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.o_wenable) wen_cycles++;
            if (bus.o_renable) ren_cycles++;
            if (bus.s_rvalid)  rv_cycles++;
            if (bus.o_wenable && bus.i_waccept) wr_obs.push_back({bus.o_wreg_idx, bus.o_wdata});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [11:0] addr);
        bit done = 1'b0;
        bus.s_awaddr  = addr;
        bus.s_awvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.s_awready) done = 1'b1;
            step();
        end
        bus.s_awvalid = 1'b0;
        chk("aw_handshake", 64'(done), 64'd1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        bit done = 1'b0;
        bus.s_wdata  = data;
        bus.s_wstrb  = strb;
        bus.s_wvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.s_wready) done = 1'b1;
            step();
        end
        bus.s_wvalid = 1'b0;
        chk("w_handshake", 64'(done), 64'd1);
    endtask

    task automatic send_ar(input logic [11:0] addr);
        bit done = 1'b0;
        bus.s_araddr  = addr;
        bus.s_arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.s_arready) done = 1'b1;
            step();
        end
        bus.s_arvalid = 1'b0;
        chk("ar_handshake", 64'(done), 64'd1);
        chk("rreg_idx", 64'(bus.o_rreg_idx), 64'(addr[11:2]));
    endtask

    task automatic wait_b();
        bit seen = 1'b0;
        logic [1:0] e;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.s_bvalid) seen = 1'b1;
            else step();
        end
        chk("b_seen", 64'(seen), 64'd1);
        if (seen && exp_b.size() > 0) begin
            e = exp_b.pop_front();
            chk("bresp", 64'(bus.s_bresp), 64'(e));
            step();
        end
    endtask

    task automatic wait_r();
        bit seen = 1'b0;
        rd_t e;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.s_rvalid) seen = 1'b1;
            else step();
        end
        chk("r_seen", 64'(seen), 64'd1);
        if (seen && exp_r.size() > 0) begin
            e = exp_r.pop_front();
            chk("rdata", 64'(bus.s_rdata), 64'(e.data));
            chk("rresp", 64'(bus.s_rresp), 64'(e.resp));
            step();
        end
    endtask

    task automatic check_writes();
        wr_t o, e;
        bit got;
        while (exp_w.size() > 0) begin
            got = (wr_obs.size() > 0);
            chk("regio_wr_present", 64'(got), 64'd1);
            if (!got) begin
                exp_w.delete();
                break;
            end
            o = wr_obs.pop_front();
            e = exp_w.pop_front();
            chk("regio_wr", 64'(o), 64'(e));
        end
        chk("regio_wr_extra", 64'(wr_obs.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, rv0;

        rst = 1'b1;
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata = '0; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b1;
        bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b1;
        wacc_en = 1'b1; racc_en = 1'b1; werr = 1'b0; rerr = 1'b0; rd_val = '0;

        // Reset values
        step(); step();
        chk("rst_ready", 64'({bus.s_awready, bus.s_wready, bus.s_arready}), 64'd0);
        chk("rst_valid", 64'({bus.s_bvalid, bus.s_rvalid, bus.o_wenable, bus.o_renable}), 64'd0);
        chk("rst_payload", 64'({bus.s_bresp, bus.s_rresp, bus.o_wreg_idx, bus.o_rreg_idx}), 64'd0);
        chk("rst_data", 64'({bus.s_rdata, bus.o_wdata}), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_ready", 64'({bus.s_awready, bus.s_wready, bus.s_arready}), 64'b111);

        // AW and W in the same cycle, immediate accept
        exp_w.push_back({10'd2, 32'h0000_0001});
        exp_b.push_back(RESP_OKAY);
        w0 = wen_cycles;
        bus.s_awaddr = 12'h008; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'h1; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        step();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        chk("t1_wenable_n1", 64'(bus.o_wenable), 64'd1);
        chk("t1_widx", 64'(bus.o_wreg_idx), 64'd2);
        chk("t1_wdata", 64'(bus.o_wdata), 64'd1);
        step();
        chk("t1_bvalid_n2", 64'(bus.s_bvalid), 64'd1);
        chk("t1_wenable_low", 64'(bus.o_wenable), 64'd0);
        wait_b();
        chk("t1_bvalid_done", 64'(bus.s_bvalid), 64'd0);
        chk("t1_wen_cycles", 64'(wen_cycles - w0), 64'd1);
        check_writes();

        // W three cycles ahead of AW
        exp_w.push_back({10'd7, 32'hA5A5_0007});
        exp_b.push_back(RESP_OKAY);
        w0 = wen_cycles;
        send_w(32'hA5A5_0007, 4'hF);
        chk("t2_wready_held", 64'(bus.s_wready), 64'd0);
        step(); step();
        chk("t2_no_early_wen", 64'(wen_cycles - w0), 64'd0);
        send_aw(12'h01C);
        chk("t2_awready_low", 64'(bus.s_awready), 64'd0);
        chk("t2_widx", 64'(bus.o_wreg_idx), 64'd7);
        step();
        chk("t2_awready_resp", 64'(bus.s_awready), 64'd0);
        wait_b();
        chk("t2_wen_cycles", 64'(wen_cycles - w0), 64'd1);
        check_writes();

        // Read with R back-pressure
        rd_val = 32'h5645_0001;
        exp_r.push_back({32'h5645_0001, RESP_OKAY});
        r0 = ren_cycles;
        bus.s_rready = 1'b0;
        send_ar(12'h000);
        chk("t3_renable_n1", 64'(bus.o_renable), 64'd1);
        step();
        chk("t3_rvalid_n2", 64'(bus.s_rvalid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("t3_hold_valid", 64'(bus.s_rvalid), 64'd1);
            chk("t3_hold_data", 64'(bus.s_rdata), 64'h5645_0001);
            step();
        end
        bus.s_rready = 1'b1;
        wait_r();
        chk("t3_rvalid_done", 64'(bus.s_rvalid), 64'd0);
        chk("t3_ren_cycles", 64'(ren_cycles - r0), 64'd1);

        // Partial strobe is refused without a RegIO write
        exp_b.push_back(RESP_SLVERR);
        w0 = wen_cycles;
        fork
            send_aw(12'h010);
            send_w(32'h0000_00FF, 4'h3);
        join
        wait_b();
        chk("t4_no_wenable", 64'(wen_cycles - w0), 64'd0);
        check_writes();

        // Read timeout
        racc_en = 1'b0;
        exp_r.push_back({TMO_RDATA, RESP_SLVERR});
        r0 = ren_cycles;
        send_ar(12'h004);
        wait_r();
        chk("t5_ren_cycles", 64'(ren_cycles - r0), 64'(TMO));
        racc_en = 1'b1;

        // Write timeout
        wacc_en = 1'b0;
        exp_b.push_back(RESP_SLVERR);
        w0 = wen_cycles;
        fork
            send_aw(12'h00C);
            send_w(32'h0000_0011, 4'hF);
        join
        wait_b();
        chk("t5_wen_cycles", 64'(wen_cycles - w0), 64'(TMO));
        wacc_en = 1'b1;
        check_writes();

        // Concurrent read and write, responder flags a write error
        werr = 1'b1;
        rd_val = 32'h1234_5678;
        exp_w.push_back({10'd8, 32'hCAFE_0008});
        exp_b.push_back(RESP_SLVERR);
        exp_r.push_back({32'h1234_5678, RESP_OKAY});
        fork
            send_aw(12'h020);
            send_w(32'hCAFE_0008, 4'hF);
            send_ar(12'h030);
        join
        fork
            wait_b();
            wait_r();
        join
        werr = 1'b0;
        check_writes();

        // Reset while a read is waiting for accept
        racc_en = 1'b0;
        send_ar(12'h040);
        step();
        chk("t6_in_rreq", 64'(bus.o_renable), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_read", 64'({bus.s_arready, bus.o_renable, bus.s_rvalid, bus.o_rreg_idx, bus.s_rresp}), 64'd0);
        chk("t6_rst_rdata", 64'(bus.s_rdata), 64'd0);
        chk("t6_rst_write", 64'({bus.s_awready, bus.s_wready, bus.s_bvalid, bus.o_wenable, bus.s_bresp, bus.o_wreg_idx}), 64'd0);
        chk("t6_rst_wdata", 64'(bus.o_wdata), 64'd0);
        rv0 = rv_cycles;
        step(); step();
        rst = 1'b0;
        racc_en = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("t6_no_r_after_rst", 64'(rv_cycles - rv0), 64'd0);
        chk("t6_idle_after_rst", 64'({bus.s_awready, bus.s_wready, bus.s_arready}), 64'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
